// File: rtl/arb_mux_pkg.sv
// arb_mux_pkg: round-robin pick and one-hot decode helpers shared by arb_mux (ARB_MUX_LOCK_EN handled by users)
package arb_mux_pkg;
    localparam int MAXN = 64;
    function automatic logic [MAXN-1:0] rr_pick(input logic [MAXN-1:0] valid, input int ptr, input int n);
        logic [MAXN-1:0] g;
        int idx;
        g = '0;
        for (int k = 0; k < MAXN; k++) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) idx -= n;
                if (valid[idx[5:0]] && g == '0) g[idx[5:0]] = 1'b1;
            end
        end
        return g;
    endfunction
    function automatic int onehot_to_idx(input logic [MAXN-1:0] oh);
        int r;
        r = 0;
        for (int i = 0; i < MAXN; i++) if (oh[i]) r |= i;
        return r;
    endfunction
endpackage

// File: rtl/arb_mux_if.sv
// arb_mux_if: producer/consumer bundle of arb_mux; master = bench side, slave = arb_mux (ARB_MUX_LOCK_EN adds in_last/out_last)
interface arb_mux_if #(parameter int SIZE = 8, parameter int N = 4);
    localparam int SELW = N > 1 ? $clog2(N) : 1;
    logic [N-1:0]      in_valid;
    logic [N*SIZE-1:0] in_data;
    logic [N-1:0]      in_ready;
    logic              out_valid;
    logic [SIZE-1:0]   out_data;
    logic [SELW-1:0]   out_sel;
    logic              out_ready;
`ifdef ARB_MUX_LOCK_EN
    logic [N-1:0]      in_last;
    logic              out_last;
    modport master(output in_valid, in_data, in_last, out_ready, input in_ready, out_valid, out_data, out_sel, out_last);
    modport slave(input in_valid, in_data, in_last, out_ready, output in_ready, out_valid, out_data, out_sel, out_last);
`else
    modport master(output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_sel);
    modport slave(input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_sel);
`endif
endinterface

// File: rtl/arb_mux_rr_arbiter.sv
// rr_arbiter: round-robin grant with pointer (and burst lock under ARB_MUX_LOCK_EN); ports: en_i, valid_i, last_i -> grant_o, idx_o
module rr_arbiter
    import arb_mux_pkg::*;
#(
    parameter int N = 4,
    localparam int SELW = N > 1 ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en_i,
    input  logic [N-1:0]    valid_i,
`ifdef ARB_MUX_LOCK_EN
    input  logic [N-1:0]    last_i,
`endif
    output logic [N-1:0]    grant_o,
    output logic [SELW-1:0] idx_o
);
    logic [SELW-1:0] ptr_q, ptr_d;
    logic [MAXN-1:0] elig;
`ifdef ARB_MUX_LOCK_EN
    logic lock_q, lock_d;
    // While locked, ptr_q names the owning channel and nobody else may compete.
    assign elig = MAXN'(lock_q ? valid_i & (N'(1) << ptr_q) : valid_i);
`else
    assign elig = MAXN'(valid_i);
`endif
    assign grant_o = en_i ? N'(rr_pick(elig, int'(ptr_q), N)) : '0;
    assign idx_o = SELW'(onehot_to_idx(MAXN'(grant_o)));
    always_comb begin
        ptr_d = ptr_q;
`ifdef ARB_MUX_LOCK_EN
        lock_d = lock_q;
`endif
        if (|grant_o) begin
            ptr_d = (int'(idx_o) == N - 1) ? '0 : idx_o + 1'b1;
`ifdef ARB_MUX_LOCK_EN
            lock_d = ~last_i[idx_o];
            if (~last_i[idx_o]) ptr_d = idx_o;
`endif
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
`ifdef ARB_MUX_LOCK_EN
            lock_q <= 1'b0;
`endif
        end else begin
            ptr_q <= ptr_d;
`ifdef ARB_MUX_LOCK_EN
            lock_q <= lock_d;
`endif
        end
    end
endmodule

// File: rtl/arb_mux.sv
// arb_mux: N-channel round-robin registered mux; ports clk, reset (async high), bus (arb_mux_if.slave); ARB_MUX_LOCK_EN adds burst lock
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter int SIZE = 8,
    parameter int N = 4
) (
    input logic       clk,
    input logic       reset,
    arb_mux_if.slave  bus
);
    localparam int SELW = N > 1 ? $clog2(N) : 1;
    logic            load, xfer, out_valid_q, out_valid_d;
    logic [N-1:0]    grant;
    logic [SELW-1:0] idx, out_sel_q, out_sel_d;
    logic [SIZE-1:0] sel_data, out_data_q, out_data_d;
    assign load = ~out_valid_q | bus.out_ready;
    assign xfer = |grant;
    rr_arbiter #(.N(N)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .en_i    (load),
        .valid_i (bus.in_valid),
`ifdef ARB_MUX_LOCK_EN
        .last_i  (bus.in_last),
`endif
        .grant_o (grant),
        .idx_o   (idx)
    );
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) sel_data |= bus.in_data[i*SIZE +: SIZE] & {SIZE{grant[i]}};
    end
    assign out_valid_d = xfer | (out_valid_q & ~bus.out_ready);
    assign out_data_d = xfer ? sel_data : out_data_q;
    assign out_sel_d = xfer ? idx : out_sel_q;
`ifdef ARB_MUX_LOCK_EN
    logic out_last_q, out_last_d;
    assign out_last_d = xfer ? |(grant & bus.in_last) : out_last_q;
    always_ff @(posedge clk or posedge reset) out_last_q <= reset ? 1'b0 : out_last_d;
    assign bus.out_last = out_last_q;
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q <= '0;
            out_sel_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q <= out_data_d;
            out_sel_q <= out_sel_d;
        end
    end
    assign bus.in_ready = grant;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data = out_data_q;
    assign bus.out_sel = out_sel_q;
endmodule

// File: tb/tb_arb_mux.sv
// tb_arb_mux: directed vectors against a queue-free round-robin model for N=4 and N=3 instances
module tb_arb_mux;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    arb_mux_if #(.SIZE(8), .N(4)) b4 ();
    arb_mux_if #(.SIZE(8), .N(3)) b3 ();
    arb_mux #(.SIZE(8), .N(4)) u4 (.clk(clk), .reset(reset), .bus(b4.slave));
    arb_mux #(.SIZE(8), .N(3)) u3 (.clk(clk), .reset(reset), .bus(b3.slave));
    int nvec = 0;
    int nerr = 0;
    int m_ptr[2], m_ov[2], m_od[2], m_os[2], m_ol[2], m_lk[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int nch(input int k);
        return k == 0 ? 4 : 3;
    endfunction
    function automatic logic [3:0] vin(input int k);
        return k == 0 ? b4.in_valid : {1'b0, b3.in_valid};
    endfunction
    function automatic logic [31:0] dat(input int k);
        return k == 0 ? b4.in_data : {8'h00, b3.in_data};
    endfunction
    function automatic logic rdy(input int k);
        return k == 0 ? b4.out_ready : b3.out_ready;
    endfunction
    function automatic logic [3:0] lst(input int k);
`ifdef ARB_MUX_LOCK_EN
        return k == 0 ? b4.in_last : {1'b1, b3.in_last};
`else
        return 4'hF;
`endif
    endfunction

    // Channel the model says is accepted this cycle, or -1.
    function automatic int pick(input int k);
        int n, c;
        logic [3:0] v;
        n = nch(k);
        v = vin(k);
        if (m_ov[k] != 0 && !rdy(k)) return -1;
        if (m_lk[k] != 0) return ((v >> m_ptr[k]) & 4'd1) != 0 ? m_ptr[k] : -1;
        for (int j = 0; j < n; j++) begin
            c = (m_ptr[k] + j) % n;
            if (((v >> c) & 4'd1) != 0) return c;
        end
        return -1;
    endfunction
    function automatic logic [31:0] exp_rdy(input int k);
        int g;
        g = pick(k);
        return g >= 0 ? 32'd1 << g : 32'd0;
    endfunction

    always @(posedge clk or posedge reset) begin : model
        int g;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_ptr[k] = 0; m_ov[k] = 0; m_od[k] = 0; m_os[k] = 0; m_ol[k] = 0; m_lk[k] = 0;
            end else begin
                g = pick(k);
                if (g >= 0) begin
                    m_od[k] = int'(8'(dat(k) >> (8 * g)));
                    m_os[k] = g;
                    m_ov[k] = 1;
                    m_ol[k] = int'((lst(k) >> g) & 4'd1);
                    if (m_ol[k] == 0) begin
                        m_lk[k] = 1;
                        m_ptr[k] = g;
                    end else begin
                        m_lk[k] = 0;
                        m_ptr[k] = (g + 1) % nch(k);
                    end
                end else if (m_ov[k] != 0 && rdy(k)) m_ov[k] = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("ready4", 32'(b4.in_ready), exp_rdy(0));
            chk("valid4", 32'(b4.out_valid), m_ov[0]);
            if (m_ov[0] != 0) begin
                chk("data4", 32'(b4.out_data), m_od[0]);
                chk("sel4", 32'(b4.out_sel), m_os[0]);
`ifdef ARB_MUX_LOCK_EN
                chk("last4", 32'(b4.out_last), m_ol[0]);
`endif
            end
            chk("ready3", 32'(b3.in_ready), exp_rdy(1));
            chk("valid3", 32'(b3.out_valid), m_ov[1]);
            if (m_ov[1] != 0) begin
                chk("data3", 32'(b3.out_data), m_od[1]);
                chk("sel3", 32'(b3.out_sel), m_os[1]);
            end
        end
    end

    initial begin
        b4.in_valid = '0; b4.in_data = '0; b4.out_ready = 1'b1;
        b3.in_valid = '0; b3.in_data = '0; b3.out_ready = 1'b1;
`ifdef ARB_MUX_LOCK_EN
        b4.in_last = '1; b3.in_last = '1;
`endif
        step(2);
        reset = 1'b0;
        chk("rst_valid", 32'(b4.out_valid), 0);
        chk("rst_data", 32'(b4.out_data), 0);
        chk("rst_sel", 32'(b4.out_sel), 0);
        b4.in_data = 32'hA3A2A1A0;
        b4.in_valid = 4'hF;
        for (int k = 0; k < 6; k++) begin
            step(1);
            chk("fair_sel", 32'(b4.out_sel), k % 4);
            chk("fair_data", 32'(b4.out_data), 32'hA0 + k % 4);
        end
        b4.in_valid = 4'b0001;
        b4.in_data = 32'h0077005C;
        step(1);
        chk("bp_load", 32'(b4.out_data), 32'h5C);
        b4.out_ready = 1'b0;
        b4.in_valid = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            step(1);
            chk("bp_hold", 32'(b4.out_data), 32'h5C);
            chk("bp_ready", 32'(b4.in_ready), 0);
        end
        b4.out_ready = 1'b1;
        #1 chk("bp_rel_ready", 32'(b4.in_ready), 32'b0100);
        step(1);
        chk("bp_refill_data", 32'(b4.out_data), 32'h77);
        chk("bp_refill_sel", 32'(b4.out_sel), 2);
        b4.in_valid = 4'b0010;
        b4.in_data = 32'h00001100;
        step(1);
        chk("idle_data", 32'(b4.out_data), 32'h11);
        chk("idle_sel", 32'(b4.out_sel), 1);
        b4.in_valid = '0;
        step(1);
        chk("idle_drop", 32'(b4.out_valid), 0);
        chk("idle_keep", 32'(b4.out_data), 32'h11);
        b4.in_valid = 4'hF;
        b4.in_data = 32'hD3D2D1D0;
        #1 chk("idle_ptr", 32'(b4.in_ready), 32'b0100);
        step(1);
        chk("pre_rst_data", 32'(b4.out_data), 32'hD2);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", 32'(b4.out_valid), 0);
        chk("arst_data", 32'(b4.out_data), 0);
        chk("arst_sel", 32'(b4.out_sel), 0);
        step(1);
        reset = 1'b0;
        #1 chk("post_rst_ready", 32'(b4.in_ready), 32'b0001);
        step(1);
        chk("post_rst_data", 32'(b4.out_data), 32'hD0);
        b4.in_valid = '0;
        b3.in_data = 24'h332211;
        b3.in_valid = 3'b010;
        step(1);
        chk("wrap_sel_a", 32'(b3.out_sel), 1);
        b3.in_valid = 3'b011;
        step(1);
        chk("wrap_sel_b", 32'(b3.out_sel), 0);
        chk("wrap_data_b", 32'(b3.out_data), 32'h11);
        step(1);
        chk("wrap_sel_c", 32'(b3.out_sel), 1);
        chk("wrap_data_c", 32'(b3.out_data), 32'h22);
        b3.in_valid = '0;
`ifdef ARB_MUX_LOCK_EN
        b4.in_valid = 4'b0010;
        b4.in_last = 4'b1101;
        b4.in_data = 32'h0000B100;
        step(1);
        chk("lock_sel1", 32'(b4.out_sel), 1);
        chk("lock_last1", 32'(b4.out_last), 0);
        b4.in_valid = 4'b0011;
        b4.in_data = 32'h0000B2C0;
        step(1);
        chk("lock_sel2", 32'(b4.out_sel), 1);
        chk("lock_data2", 32'(b4.out_data), 32'hB2);
        b4.in_last = 4'b1111;
        b4.in_data = 32'h0000B3C0;
        step(1);
        chk("lock_sel3", 32'(b4.out_sel), 1);
        chk("lock_last3", 32'(b4.out_last), 1);
        step(1);
        chk("lock_sel4", 32'(b4.out_sel), 0);
        chk("lock_data4", 32'(b4.out_data), 32'hC0);
        b4.in_valid = '0;
`endif
        step(2);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
